// File: rtl/boot_loader_seq_if.sv
// Boot ROM read port and main-memory write port used by the boot sequencer.
// Handshake: mem_wr is valid and mem_ack is ready. A write transfers on a rising edge where both are 1, and mem_addr/mem_data stay stable while mem_wr=1. rom_data must be valid combinationally in the same cycle as rom_rd.
interface boot_loader_seq_if;
  logic [12:0] rom_addr;
  logic        rom_rd;
  logic [15:0] rom_data;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_wr;
  logic        mem_ack;

  modport master (
    output rom_addr, rom_rd, mem_addr, mem_data, mem_wr,
    input  rom_data, mem_ack
  );

  modport slave (
    input  rom_addr, rom_rd, mem_addr, mem_data, mem_wr,
    output rom_data, mem_ack
  );
endinterface

// File: rtl/boot_loader_seq.sv
// Power-up boot sequencer: keeps the CPU halted and copies the boot ROM image into main memory.
// It then loads the start PC and releases the CPU, and keeps an additive checksum of the copied words.
module boot_loader_seq #(
  parameter logic [12:0] SRC_BASE   = 13'o13000,
  parameter logic [15:0] DST_BASE   = 16'o001000,
  parameter int          COPY_WORDS = 512,
  parameter logic [15:0] START_PC   = 16'o001000,
  parameter int          TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      boot_en,
  input  logic                      start,
  boot_loader_seq_if.master         bus,
  output logic                      cpu_halt,
  output logic [15:0]               cpu_pc,
  output logic                      cpu_pc_load,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [15:0]               checksum,
  output logic [2:0]                dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WRITE  = 3'd2,
    S_LOADPC = 3'd3,
    S_RUN    = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  localparam int       TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [9:0]    LAST_IDX = 10'(COPY_WORDS - 1);

  state_e        state_q, state_d;
  logic [9:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   sum_q, sum_d;
  logic [15:0]   data_q, data_d;

  logic          halt_q, halt_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;
  logic          mem_wr_q, mem_wr_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic          pc_load_q, pc_load_d;
  logic [15:0]   pc_q, pc_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tmo_q      <= '0;
      sum_q      <= '0;
      data_q     <= '0;
      halt_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      pc_load_q  <= 1'b0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      sum_q      <= sum_d;
      data_q     <= data_d;
      halt_q     <= halt_d;
      done_q     <= done_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      pc_load_q  <= pc_load_d;
      pc_q       <= pc_d;
    end
  end

  // Next-state logic. mem_ack only matters in WRITE, which is exactly when mem_wr is high.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    sum_d   = sum_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: state_d = boot_en ? S_READ : S_RUN;
      S_READ: begin
        data_d  = bus.rom_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          sum_d   = sum_q + data_q;
          idx_d   = idx_q + 10'd1;
          tmo_d   = '0;
          state_d = (idx_q == LAST_IDX) ? S_LOADPC : S_READ;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_LOADPC: state_d = S_RUN;
      S_RUN, S_ERR: begin
        if (start) begin
          state_d = S_IDLE;
          idx_d   = '0;
          sum_d   = '0;
          tmo_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state, so they change together with the state register.
  always_comb begin
    halt_d     = (state_d != S_RUN);
    done_d     = (state_d == S_RUN);
    error_d    = (state_d == S_ERR);
    busy_d     = (state_d == S_READ) || (state_d == S_WRITE);
    mem_wr_d   = (state_d == S_WRITE);
    pc_load_d  = (state_d == S_LOADPC);
    pc_d       = (state_d == S_LOADPC) ? START_PC : pc_q;
    mem_addr_d = mem_addr_q;
    if (state_d == S_WRITE) begin
      mem_addr_d = DST_BASE + {5'b0, idx_d, 1'b0};
    end
  end

  assign bus.rom_rd   = (state_q == S_READ);
  assign bus.rom_addr = (state_q == S_READ) ? (SRC_BASE + {2'b0, idx_q, 1'b0}) : 13'd0;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = data_q;
  assign bus.mem_wr   = mem_wr_q;

  assign cpu_halt    = halt_q;
  assign cpu_pc      = pc_q;
  assign cpu_pc_load = pc_load_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign checksum    = sum_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_boot_loader_seq.sv
// Bench for boot_loader_seq: ROM and memory models, a write scoreboard fed from an image-level reference, directed and randomized boots.
module tb_boot_loader_seq;
  localparam logic [12:0] SRC = 13'o13000;
  localparam logic [15:0] DST = 16'o001000;
  localparam logic [15:0] PC  = 16'o001000;
  localparam int          NW  = 4;
  localparam int          TMO = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic boot_en = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  boot_loader_seq_if bus_if ();
  logic        cpu_halt, cpu_pc_load, busy, done, error;
  logic [15:0] cpu_pc, checksum;
  logic [2:0]  dbg_state;

  boot_loader_seq #(
    .SRC_BASE(SRC), .DST_BASE(DST), .COPY_WORDS(NW), .START_PC(PC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .boot_en(boot_en), .start(start), .bus(bus_if.master),
    .cpu_halt(cpu_halt), .cpu_pc(cpu_pc), .cpu_pc_load(cpu_pc_load), .busy(busy),
    .done(done), .error(error), .checksum(checksum), .dbg_state_o(dbg_state)
  );

  // ROM model: image words at SRC, SRC+2, ...; anything else reads as 16'hdead
  logic [15:0] rom_img [0:NW-1];
  logic [12:0] rom_off;
  int          rom_i;
  always_comb begin
    rom_off = bus_if.rom_addr - SRC;
    rom_i   = int'(rom_off[12:1]);
    bus_if.rom_data = 16'hdead;
    if (!rom_off[0] && rom_i < NW) bus_if.rom_data = rom_img[rom_i];
  end

  // memory ack driver: 0 = tied high, 1 = random delay in [dly_min,dly_max], 2 = stuck low
  int ack_mode = 0;
  int dly_min = 0, dly_max = 0;
  int wait_cnt = 0, cur_dly = 0;
  initial begin
    bus_if.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      case (ack_mode)
        0: bus_if.mem_ack = 1'b1;
        1: begin
          if (bus_if.mem_wr) begin
            if (wait_cnt >= cur_dly) begin
              bus_if.mem_ack = 1'b1;
              wait_cnt = 0;
              cur_dly = $urandom_range(dly_max, dly_min);
            end else begin
              bus_if.mem_ack = 1'b0;
              wait_cnt++;
            end
          end else begin
            bus_if.mem_ack = 1'b0;
            wait_cnt = 0;
          end
        end
        default: bus_if.mem_ack = 1'b0;
      endcase
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_sum;
  int rd_cnt, wr_cnt, pcl_cnt, pcl_rel;
  bit timing_on = 0;
  int t_first, t_step;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic clear_counts();
    rd_cnt = 0; wr_cnt = 0; pcl_cnt = 0; pcl_rel = -100;
  endtask

  // reference: the image lands word-for-word at DST, checksum is the plain sum mod 2^16
  task automatic load_expect();
    int s;
    s = 0;
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      exp_q.push_back({DST + 16'(2 * i), rom_img[i]});
      s += int'(rom_img[i]);
    end
    exp_sum = 16'(s);
  endtask

  task automatic rand_image();
    for (int i = 0; i < NW; i++) rom_img[i] = 16'($urandom);
  endtask

  // monitor
  bit          prev_wr = 0, prev_acc = 0, acc;
  logic [15:0] prev_addr, prev_data;
  logic [31:0] exp_w;
  int          rel;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!reset_n) begin
        prev_wr = 0;
      end else begin
        rel = cyc - base;
        check("busy", {31'b0, busy}, {31'b0, bus_if.rom_rd | bus_if.mem_wr});
        if (bus_if.rom_rd) begin
          check("rom_addr", {19'b0, bus_if.rom_addr}, {19'b0, SRC + 13'(2 * rd_cnt)});
          rd_cnt++;
        end
        if (cpu_pc_load) begin
          pcl_cnt++;
          pcl_rel = rel;
          check("pc_value", {16'b0, cpu_pc}, {16'b0, PC});
          check("halt_at_pcload", {31'b0, cpu_halt}, 32'd1);
        end
        if (bus_if.mem_wr && prev_wr && !prev_acc) begin
          check("addr_stable", {16'b0, bus_if.mem_addr}, {16'b0, prev_addr});
          check("data_stable", {16'b0, bus_if.mem_data}, {16'b0, prev_data});
        end
        acc = bus_if.mem_wr && bus_if.mem_ack;
        if (acc) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got %0h:%0h expected none", bus_if.mem_addr, bus_if.mem_data);
          end else begin
            exp_w = exp_q.pop_front();
            check("write", {bus_if.mem_addr, bus_if.mem_data}, exp_w);
          end
          if (timing_on) check("write_cycle", rel, t_first + t_step * wr_cnt);
          wr_cnt++;
        end
        prev_wr = bus_if.mem_wr;
        prev_acc = acc;
        prev_addr = bus_if.mem_addr;
        prev_data = bus_if.mem_data;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    clear_counts();
    reset_n = 1'b1;
    base = cyc;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_halt", {31'b0, cpu_halt}, 32'd1);
    check("rst_checksum", {16'b0, checksum}, 32'd0);
  endtask

  task automatic wait_end(input int max, output bit ok);
    int n;
    ok = 0;
    n = 0;
    while (!ok && n < max) begin
      @(negedge clk); #1;
      n++;
      if (done || error) ok = 1;
    end
  endtask

  task automatic finish_copy(input string tag);
    bit ok;
    int drel;
    wait_end(400, ok);
    check({tag, "_ended"}, {31'b0, ok}, 32'd1);
    drel = cyc - base;
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_error"}, {31'b0, error}, 32'd0);
    check({tag, "_halt"}, {31'b0, cpu_halt}, 32'd0);
    check({tag, "_checksum"}, {16'b0, checksum}, {16'b0, exp_sum});
    check({tag, "_writes_left"}, exp_q.size(), 32'd0);
    check({tag, "_reads"}, rd_cnt, NW);
    check({tag, "_pcloads"}, pcl_cnt, 32'd1);
    check({tag, "_halt_release"}, drel, pcl_rel + 1);
    check({tag, "_cpu_pc"}, {16'b0, cpu_pc}, {16'b0, PC});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k;
    clear_counts();
    // reset values
    repeat (2) @(negedge clk);
    check("reset_halt", {31'b0, cpu_halt}, 32'd1);
    check("reset_memwr", {31'b0, bus_if.mem_wr}, 32'd0);
    check("reset_romrd", {31'b0, bus_if.rom_rd}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_error", {31'b0, error}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_pcload", {31'b0, cpu_pc_load}, 32'd0);
    check("reset_checksum", {16'b0, checksum}, 32'd0);
    check("reset_pc", {16'b0, cpu_pc}, 32'd0);
    check("reset_memaddr", {16'b0, bus_if.mem_addr}, 32'd0);

    // directed image, ack tied high: writes on cycles 2,4,6,8
    rom_img[0] = 16'o000240; rom_img[1] = 16'o012706;
    rom_img[2] = 16'o007000; rom_img[3] = 16'o004737;
    ack_mode = 0; boot_en = 1'b1;
    timing_on = 1; t_first = 2; t_step = 2;
    do_reset();
    load_expect();
    finish_copy("directed");
    check("directed_pcload_cycle", pcl_rel, 2 * NW + 1);
    timing_on = 0;

    // boot_en=0: straight to RUN, no copy
    boot_en = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    #1;
    check("nocopy_halt", {31'b0, cpu_halt}, 32'd0);
    check("nocopy_done", {31'b0, done}, 32'd1);
    repeat (10) @(negedge clk);
    check("nocopy_reads", rd_cnt, 32'd0);
    check("nocopy_writes", wr_cnt, 32'd0);
    check("nocopy_pcloads", pcl_cnt, 32'd0);

    // restart from RUN with boot_en now set
    boot_en = 1'b1;
    ack_mode = 1; dly_min = 0; dly_max = 7;
    rand_image();
    clear_counts();
    load_expect();
    pulse_restart();
    finish_copy("restart_run");

    // fixed 3-cycle ack delay: 5 cycles per word
    ack_mode = 1; dly_min = 3; dly_max = 3; cur_dly = 3;
    rand_image();
    timing_on = 1; t_first = 5; t_step = 5;
    do_reset();
    load_expect();
    finish_copy("slow_ack");
    timing_on = 0;

    // ack stuck low: ERR after 8 WRITE cycles on word 0
    ack_mode = 2;
    rand_image();
    do_reset();
    load_expect();
    wait_end(100, ok);
    check("tmo_reached", {31'b0, ok}, 32'd1);
    check("tmo_cycle", cyc - base, 32'd10);
    check("tmo_error", {31'b0, error}, 32'd1);
    check("tmo_halt", {31'b0, cpu_halt}, 32'd1);
    check("tmo_memwr", {31'b0, bus_if.mem_wr}, 32'd0);
    check("tmo_done", {31'b0, done}, 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("tmo_error_held", {31'b0, error}, 32'd1);
    check("tmo_writes", wr_cnt, 32'd0);
    ack_mode = 1; dly_min = 0; dly_max = 7;
    rand_image();
    clear_counts();
    load_expect();
    pulse_restart();
    finish_copy("after_err");

    // asynchronous reset while word 2 is being written
    ack_mode = 1; dly_min = 3; dly_max = 3; cur_dly = 3;
    rand_image();
    do_reset();
    load_expect();
    k = 0;
    while (!(wr_cnt == 2 && bus_if.mem_wr) && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check("reach_word2", {31'b0, (wr_cnt == 2 && bus_if.mem_wr)}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_halt", {31'b0, cpu_halt}, 32'd1);
    check("async_memwr", {31'b0, bus_if.mem_wr}, 32'd0);
    do_reset();
    load_expect();
    finish_copy("after_async_reset");

    // checksum wraps modulo 2^16
    rom_img[0] = 16'o177777; rom_img[1] = 16'o000002;
    rom_img[2] = 16'o000000; rom_img[3] = 16'o000000;
    ack_mode = 1; dly_min = 0; dly_max = 2;
    do_reset();
    load_expect();
    finish_copy("wrap");
    check("wrap_value", {16'b0, checksum}, 32'd1);

    // random rounds via restart, with start pulsed mid-copy (must be ignored)
    for (int r = 0; r < 4; r++) begin
      ack_mode = 1; dly_min = 0; dly_max = 7;
      rand_image();
      clear_counts();
      load_expect();
      pulse_restart();
      k = $urandom_range(6, 1);
      repeat (k) @(negedge clk);
      if (busy) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      finish_copy("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
